// File: rtl/pwm_pkg.sv
// Shared constants and the CH*W packing helper for the pwm_bank PWM generator.
package pwm_pkg;

  localparam int unsigned PWM_CH_DEF     = 4;
  localparam int unsigned PWM_W_DEF      = 7;
  localparam int unsigned PWM_DEAD_W_DEF = 4;

  // LSB position of channel idx inside a vector of CH packed W-bit fields.
  function automatic int unsigned ch_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/pwm_bank_if.sv
// Control/status bundle between a host and pwm_bank.
// PWM_DEADTIME_EN adds the dead-time input and the complementary outputs.
interface pwm_bank_if #(
  parameter int unsigned CH = pwm_pkg::PWM_CH_DEF,
  parameter int unsigned W  = pwm_pkg::PWM_W_DEF
`ifdef PWM_DEADTIME_EN
  , parameter int unsigned DEAD_W = pwm_pkg::PWM_DEAD_W_DEF
`endif
);

  logic            en;
  logic [W-1:0]    period;
  logic [CH*W-1:0] set_val;
  logic [CH*W-1:0] rst_val;
  logic            load;
  logic            load_ack;
  logic [W-1:0]    cnt;
  logic            period_start;
  logic [CH-1:0]   signal;
`ifdef PWM_DEADTIME_EN
  logic [DEAD_W-1:0] dead;
  logic [CH-1:0]     signal_n;

  modport master (output en, period, set_val, rst_val, load, dead,
                  input  load_ack, cnt, period_start, signal, signal_n);
  modport slave  (input  en, period, set_val, rst_val, load, dead,
                  output load_ack, cnt, period_start, signal, signal_n);
`else
  modport master (output en, period, set_val, rst_val, load,
                  input  load_ack, cnt, period_start, signal);
  modport slave  (input  en, period, set_val, rst_val, load,
                  output load_ack, cnt, period_start, signal);
`endif

endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: reset-priority compare flop on the active compare values,
// plus an optional dead-time stage (PWM_DEADTIME_EN).
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned W = PWM_W_DEF
`ifdef PWM_DEADTIME_EN
  , parameter int unsigned DEAD_W = PWM_DEAD_W_DEF
`endif
) (
  input  logic              clkCore,
  input  logic              reset,
  input  logic              en_i,
  input  logic [W-1:0]      cnt_i,
  input  logic [W-1:0]      set_i,
  input  logic [W-1:0]      rst_i,
`ifdef PWM_DEADTIME_EN
  input  logic [DEAD_W-1:0] dead_i,
  output logic              signal_n_o,
`endif
  output logic              signal_o
);

  logic ideal_q, ideal_d;

  // Reset compare wins over set compare, so set==rst keeps the channel low.
  always_comb begin
    ideal_d = ideal_q;
    if (!en_i)               ideal_d = 1'b0;
    else if (cnt_i == rst_i) ideal_d = 1'b0;
    else if (cnt_i == set_i) ideal_d = 1'b1;
  end

  always_ff @(posedge clkCore) begin
    if (reset) ideal_q <= 1'b0;
    else       ideal_q <= ideal_d;
  end

`ifdef PWM_DEADTIME_EN
  logic [DEAD_W-1:0] dead_q, dead_d;
  logic              sig_q, sig_d, sig_n_q, sig_n_d;

  // Every ideal edge blanks both sides for dead_i cycles; an edge arriving
  // while blanking restarts it, which swallows pulses shorter than the gap.
  always_comb begin
    dead_d  = dead_q;
    sig_d   = ideal_d;
    sig_n_d = !ideal_d;
    if (ideal_d != ideal_q) begin
      dead_d = dead_i;
      if (dead_i != '0) begin
        sig_d   = 1'b0;
        sig_n_d = 1'b0;
      end
    end else if (dead_q != '0) begin
      dead_d = dead_q - DEAD_W'(1);
      if (dead_q != DEAD_W'(1)) begin
        sig_d   = 1'b0;
        sig_n_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clkCore) begin
    if (reset) begin
      dead_q  <= '0;
      sig_q   <= 1'b0;
      sig_n_q <= 1'b0;
    end else begin
      dead_q  <= dead_d;
      sig_q   <= sig_d;
      sig_n_q <= sig_n_d;
    end
  end

  assign signal_o   = sig_q;
  assign signal_n_o = sig_n_q;
`else
  assign signal_o = ideal_q;
`endif

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator: shared period counter, double-buffered compare
// values swapped at period boundaries, CH pwm_channel instances.
// Optional feature macro: PWM_DEADTIME_EN (dead-time + complementary outputs).
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int unsigned CH = PWM_CH_DEF,
  parameter int unsigned W  = PWM_W_DEF
`ifdef PWM_DEADTIME_EN
  , parameter int unsigned DEAD_W = PWM_DEAD_W_DEF
`endif
) (
  input logic       clkCore,
  input logic       reset,
  pwm_bank_if.slave bus
);

  logic [W-1:0]    cnt_q, cnt_d;
  logic [W-1:0]    period_s_q, period_s_d, period_a_q, period_a_d;
  logic [CH*W-1:0] set_s_q, set_s_d, set_a_q, set_a_d;
  logic [CH*W-1:0] rst_s_q, rst_s_d, rst_a_q, rst_a_d;
  logic            pending_q, pending_d;
  logic            load_ack_q, load_ack_d;
  logic            boundary;

  // Disabling acts like a wrap: counter returns to 0 and pending values go live.
  assign boundary = !bus.en || (cnt_q == period_a_q);

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path infers a latch.
    period_s_d = period_s_q;
    set_s_d    = set_s_q;
    rst_s_d    = rst_s_q;
    period_a_d = period_a_q;
    set_a_d    = set_a_q;
    rst_a_d    = rst_a_q;
    pending_d  = pending_q;
    load_ack_d = 1'b0;
    if (bus.load) begin
      period_s_d = bus.period;
      set_s_d    = bus.set_val;
      rst_s_d    = bus.rst_val;
      pending_d  = 1'b1;
    end
    if (boundary && pending_d) begin
      period_a_d = period_s_d;
      set_a_d    = set_s_d;
      rst_a_d    = rst_s_d;
      pending_d  = 1'b0;
      load_ack_d = 1'b1;
    end
    cnt_d = boundary ? '0 : cnt_q + W'(1);
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clkCore) begin
    if (reset) begin
      cnt_q      <= '0;
      period_s_q <= '0;
      set_s_q    <= '0;
      rst_s_q    <= '0;
      period_a_q <= '0;
      set_a_q    <= '0;
      rst_a_q    <= '0;
      pending_q  <= 1'b0;
      load_ack_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      period_s_q <= period_s_d;
      set_s_q    <= set_s_d;
      rst_s_q    <= rst_s_d;
      period_a_q <= period_a_d;
      set_a_q    <= set_a_d;
      rst_a_q    <= rst_a_d;
      pending_q  <= pending_d;
      load_ack_q <= load_ack_d;
    end
  end

  logic [CH-1:0] signal_w;
`ifdef PWM_DEADTIME_EN
  logic [CH-1:0] signal_n_w;
  assign bus.signal_n = signal_n_w;
`endif

  for (genvar i = 0; i < CH; i++) begin : g_ch
    pwm_channel #(
      .W(W)
`ifdef PWM_DEADTIME_EN
      , .DEAD_W(DEAD_W)
`endif
    ) u_ch (
      .clkCore    (clkCore),
      .reset      (reset),
      .en_i       (bus.en),
      .cnt_i      (cnt_q),
      .set_i      (set_a_q[ch_lsb(i, W) +: W]),
      .rst_i      (rst_a_q[ch_lsb(i, W) +: W]),
`ifdef PWM_DEADTIME_EN
      .dead_i     (bus.dead),
      .signal_n_o (signal_n_w[i]),
`endif
      .signal_o   (signal_w[i])
    );
  end

  assign bus.signal       = signal_w;
  assign bus.cnt          = cnt_q;
  assign bus.load_ack     = load_ack_q;
  assign bus.period_start = bus.en && !reset && (cnt_q == '0);

endmodule

// File: tb/tb_pwm_bank.sv
// Scoreboard bench for pwm_bank: a behavioural model pushes expected values per
// clock, a monitor pops them; each scenario task adds its own direct checks.
module tb_pwm_bank;
  import pwm_pkg::*;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 7;
`ifdef PWM_DEADTIME_EN
  localparam int unsigned DEAD_W = 4;
`endif

  typedef struct {
    logic [W-1:0]  cnt;
    logic [CH-1:0] sig;
    logic          ack;
    logic          ps;
  } exp_t;

  logic clkCore = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic cmp_sig = 1'b1;

  exp_t sb_q[$];
  exp_t mon_e;

  // model state
  logic [W-1:0]  m_cnt, m_per, m_sh_per;
  logic [W-1:0]  m_set[CH], m_rst[CH], m_sh_set[CH], m_sh_rst[CH];
  logic          m_pend, m_ack;
  logic [CH-1:0] m_sig;

  always #5 clkCore = ~clkCore;

`ifdef PWM_DEADTIME_EN
  pwm_bank_if #(.CH(CH), .W(W), .DEAD_W(DEAD_W)) bus ();
  pwm_bank #(.CH(CH), .W(W), .DEAD_W(DEAD_W)) dut (
    .clkCore(clkCore), .reset(reset), .bus(bus));
`else
  pwm_bank_if #(.CH(CH), .W(W)) bus ();
  pwm_bank #(.CH(CH), .W(W)) dut (
    .clkCore(clkCore), .reset(reset), .bus(bus));
`endif

  task automatic set_ch(input int i, input int s, input int r);
    bus.set_val[i*W +: W] = W'(s);
    bus.rst_val[i*W +: W] = W'(r);
  endtask

  // Advance the model by one edge with the currently driven inputs, queue the
  // expected post-edge outputs, then step the clock. Inputs change at +2.
  task automatic tick();
    exp_t          e;
    logic [CH-1:0] nsig;
    logic          bnd;
    if (reset) begin
      m_cnt = '0; m_per = '0; m_sh_per = '0; m_pend = 1'b0; m_ack = 1'b0; nsig = '0;
      for (int i = 0; i < CH; i++) begin
        m_set[i] = '0; m_rst[i] = '0; m_sh_set[i] = '0; m_sh_rst[i] = '0;
      end
    end else begin
      bnd = !bus.en || (m_cnt == m_per);
      for (int i = 0; i < CH; i++) begin
        if (!bus.en)                nsig[i] = 1'b0;
        else if (m_cnt == m_rst[i]) nsig[i] = 1'b0;
        else if (m_cnt == m_set[i]) nsig[i] = 1'b1;
        else                        nsig[i] = m_sig[i];
      end
      if (bus.load) begin
        m_sh_per = bus.period;
        for (int i = 0; i < CH; i++) begin
          m_sh_set[i] = bus.set_val[i*W +: W];
          m_sh_rst[i] = bus.rst_val[i*W +: W];
        end
        m_pend = 1'b1;
      end
      m_ack = 1'b0;
      if (bnd && m_pend) begin
        m_per = m_sh_per;
        for (int i = 0; i < CH; i++) begin
          m_set[i] = m_sh_set[i];
          m_rst[i] = m_sh_rst[i];
        end
        m_pend = 1'b0;
        m_ack  = 1'b1;
      end
      m_cnt = bnd ? '0 : m_cnt + W'(1);
    end
    m_sig = nsig;
    e.cnt = m_cnt;
    e.sig = m_sig;
    e.ack = m_ack;
    e.ps  = !reset && bus.en && (m_cnt == '0);
    sb_q.push_back(e);
    @(posedge clkCore);
    #2;
  endtask

  always @(posedge clkCore) begin
    #1;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (bus.cnt !== mon_e.cnt || bus.load_ack !== mon_e.ack ||
          bus.period_start !== mon_e.ps || (cmp_sig && bus.signal !== mon_e.sig)) begin
        errors++;
        $display("FAIL scoreboard t=%0t got cnt=%0d ack=%b ps=%b sig=%b expected cnt=%0d ack=%b ps=%b sig=%b",
                 $time, bus.cnt, bus.load_ack, bus.period_start, bus.signal,
                 mon_e.cnt, mon_e.ack, mon_e.ps, mon_e.sig);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.en = (k == 2);
      tick();
      checks++;
      if (bus.cnt !== '0 || bus.signal !== '0 || bus.load_ack !== 1'b0 || bus.period_start !== 1'b0) begin
        errors++;
        $display("FAIL reset_state cnt=%0d sig=%b ack=%b ps=%b expected all zero",
                 bus.cnt, bus.signal, bus.load_ack, bus.period_start);
      end
    end
    reset  = 1'b0;
    bus.en = 1'b0;
  endtask

  task automatic test_basic();
    int ps_count = 0;
    bus.period = 7'd9;
    set_ch(0, 2, 6);
    for (int i = 1; i < CH; i++) set_ch(i, 127, 127);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    checks++;
    if (bus.load_ack !== 1'b1 || bus.cnt !== '0) begin
      errors++;
      $display("FAIL basic_load_while_idle ack=%b cnt=%0d expected ack=1 cnt=0", bus.load_ack, bus.cnt);
    end
    bus.en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      ps_count += int'(bus.period_start);
      checks++;
      if (bus.signal[0] !== (bus.cnt >= 3 && bus.cnt <= 6)) begin
        errors++;
        $display("FAIL basic_wave cnt=%0d sig0=%b expected %b", bus.cnt, bus.signal[0], (bus.cnt >= 3 && bus.cnt <= 6));
      end
    end
    checks++;
    if (ps_count != 3) begin
      errors++;
      $display("FAIL basic_period_start count=%0d expected 3", ps_count);
    end
  endtask

  task automatic test_reload();
    for (int k = 0; k < 20 && bus.cnt !== 7'd5; k++) tick();
    checks++;
    if (bus.cnt !== 7'd5) begin
      errors++;
      $display("FAIL reload_wait_cnt5 cnt=%0d expected 5", bus.cnt);
    end
    set_ch(0, 0, 9);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int k = 0; k < 20 && bus.load_ack !== 1'b1; k++) begin
      checks++;
      if (bus.signal[0] !== (bus.cnt >= 3 && bus.cnt <= 6)) begin
        errors++;
        $display("FAIL reload_old_wave cnt=%0d sig0=%b", bus.cnt, bus.signal[0]);
      end
      tick();
    end
    checks++;
    if (bus.load_ack !== 1'b1 || bus.cnt !== '0) begin
      errors++;
      $display("FAIL reload_ack ack=%b cnt=%0d expected ack=1 cnt=0", bus.load_ack, bus.cnt);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (bus.signal[0] !== (bus.cnt != 0)) begin
        errors++;
        $display("FAIL reload_new_wave cnt=%0d sig0=%b expected %b", bus.cnt, bus.signal[0], (bus.cnt != 0));
      end
    end
  endtask

  task automatic test_boundary();
    logic seen2 = 1'b0;
    logic seen3 = 1'b0;
    bus.period = 7'd9;
    set_ch(0, 2, 6);
    set_ch(1, 4, 4);
    set_ch(2, 0, 15);
    set_ch(3, 5, 100);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int k = 0; k < 20 && bus.load_ack !== 1'b1; k++) tick();
    checks++;
    if (bus.load_ack !== 1'b1) begin
      errors++;
      $display("FAIL boundary_ack_timeout ack=%b expected 1", bus.load_ack);
    end
    for (int k = 0; k < 25; k++) begin
      tick();
      if (bus.cnt == 1) seen2 = 1'b1;
      if (bus.cnt == 6) seen3 = 1'b1;
      checks++;
      if (bus.signal[1] !== 1'b0 || (seen2 && bus.signal[2] !== 1'b1) || (seen3 && bus.signal[3] !== 1'b1)) begin
        errors++;
        $display("FAIL boundary_duty cnt=%0d sig=%b expected sig1=0 sig2=%b sig3=%b",
                 bus.cnt, bus.signal, seen2, seen3);
      end
    end
    bus.period = '0;
    bus.load   = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int k = 0; k < 20 && bus.load_ack !== 1'b1; k++) tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (bus.cnt !== '0 || bus.period_start !== 1'b1) begin
        errors++;
        $display("FAIL boundary_period0 cnt=%0d ps=%b expected cnt=0 ps=1", bus.cnt, bus.period_start);
      end
    end
  endtask

  task automatic test_enable_reset();
    bus.period = 7'd9;
    set_ch(0, 2, 6);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int k = 0; k < 20 && bus.cnt !== 7'd3; k++) tick();
    set_ch(0, 1, 8);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    checks++;
    if (bus.cnt !== 7'd4 || bus.signal[0] !== 1'b1) begin
      errors++;
      $display("FAIL enable_pre cnt=%0d sig0=%b expected cnt=4 sig0=1", bus.cnt, bus.signal[0]);
    end
    bus.en = 1'b0;
    tick();
    checks++;
    if (bus.cnt !== '0 || bus.signal !== '0 || bus.load_ack !== 1'b1 || bus.period_start !== 1'b0) begin
      errors++;
      $display("FAIL enable_drop cnt=%0d sig=%b ack=%b ps=%b expected 0 0000 1 0",
               bus.cnt, bus.signal, bus.load_ack, bus.period_start);
    end
    bus.en = 1'b1;
    repeat (12) tick();
    bus.period = 7'd5;
    bus.load   = 1'b1;
    tick();
    bus.load = 1'b0;
    reset    = 1'b1;
    tick();
    checks++;
    if (bus.cnt !== '0 || bus.signal !== '0 || bus.load_ack !== 1'b0 || bus.period_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid cnt=%0d sig=%b ack=%b ps=%b expected all zero",
               bus.cnt, bus.signal, bus.load_ack, bus.period_start);
    end
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if (bus.cnt !== '0 || bus.load_ack !== 1'b0 || bus.signal !== '0) begin
        errors++;
        $display("FAIL reset_discard cnt=%0d ack=%b sig=%b expected 0 0 0000", bus.cnt, bus.load_ack, bus.signal);
      end
    end
  endtask

  task automatic test_channels();
    int hi[CH];
    int want[CH] = '{4, 9, 2, 15};
    bus.period = 7'd15;
    set_ch(0, 1, 5);
    set_ch(1, 3, 12);
    set_ch(2, 7, 9);
    set_ch(3, 0, 15);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < CH; i++) set_ch(i, 10, 11);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    tick();
    set_ch(0, 1, 5);
    set_ch(1, 3, 12);
    set_ch(2, 7, 9);
    set_ch(3, 0, 15);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int k = 0; k < 20 && bus.load_ack !== 1'b1; k++) tick();
    checks++;
    if (bus.load_ack !== 1'b1 || bus.cnt !== '0) begin
      errors++;
      $display("FAIL channels_ack ack=%b cnt=%0d expected ack=1 cnt=0", bus.load_ack, bus.cnt);
    end
    repeat (16) tick();
    for (int i = 0; i < CH; i++) hi[i] = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      for (int i = 0; i < CH; i++) hi[i] += int'(bus.signal[i]);
    end
    for (int i = 0; i < CH; i++) begin
      checks++;
      if (hi[i] != want[i]) begin
        errors++;
        $display("FAIL channels_duty ch=%0d high=%0d expected %0d", i, hi[i], want[i]);
      end
    end
  endtask

`ifdef PWM_DEADTIME_EN
  task automatic test_deadtime();
    logic s0, n0, n1;
    bus.period = 7'd9;
    set_ch(0, 2, 6);
    set_ch(1, 4, 5);
    set_ch(2, 127, 127);
    set_ch(3, 127, 127);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int k = 0; k < 20 && bus.load_ack !== 1'b1; k++) tick();
    cmp_sig  = 1'b0;
    bus.dead = 4'd2;
    repeat (10) tick();
    for (int k = 0; k < 20; k++) begin
      tick();
      s0 = (bus.cnt == 5 || bus.cnt == 6);
      n0 = (bus.cnt == 9 || bus.cnt <= 2);
      n1 = !(bus.cnt >= 5 && bus.cnt <= 7);
      checks++;
      if (bus.signal[0] !== s0 || bus.signal_n[0] !== n0 || bus.signal[1] !== 1'b0 ||
          bus.signal_n[1] !== n1 || (bus.signal & bus.signal_n) !== '0) begin
        errors++;
        $display("FAIL deadtime cnt=%0d sig=%b sig_n=%b expected s0=%b n0=%b s1=0 n1=%b",
                 bus.cnt, bus.signal, bus.signal_n, s0, n0, n1);
      end
    end
    cmp_sig = 1'b1;
  endtask
`endif

  initial begin
    reset       = 1'b1;
    bus.en      = 1'b0;
    bus.load    = 1'b0;
    bus.period  = '0;
    bus.set_val = '0;
    bus.rst_val = '0;
`ifdef PWM_DEADTIME_EN
    bus.dead    = '0;
`endif
    #2;
    test_reset();
    test_basic();
    test_reload();
    test_boundary();
    test_enable_reset();
    test_channels();
`ifdef PWM_DEADTIME_EN
    test_deadtime();
`endif
    @(posedge clkCore);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pwm_bank.md
# pwm_bank

Multi-channel, single-clock PWM generator: the parametrised successor of the dual-counter/RS-latch PWM stage used on the photonic switch drivers. One shared up-counter sets the period. Each channel has its own set and reset compare values, so each output can have an arbitrary rising and falling position within the period. Compare values are double-buffered and swap only at a period boundary, so a reload never causes a glitch.

## Interface
- CH, 4, number of PWM channels (1..16)
- W, 7, counter and compare width in bits
- DEAD_W, 4, dead-time counter width (used only with PWM_DEADTIME_EN)

- clkCore  in  1  core clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- en  in  1  run enable; 0 holds the counter at 0 and forces outputs low
- period  in  W  terminal count; period length = period+1 cycles
- set_val  in  CH*W  per-channel rise position; channel i is at bits [i*W +: W]
- rst_val  in  CH*W  per-channel fall position; same packing as set_val
- load  in  1  single-cycle request to capture period/set_val/rst_val into shadow registers
- load_ack  out  1  one-cycle pulse when the shadow registers become active
- cnt  out  W  current counter value
- period_start  out  1  high during every cycle where cnt==0 and en=1
- signal  out  CH  PWM outputs, registered
- dead  in  DEAD_W  dead-time in cycles (PWM_DEADTIME_EN only)
- signal_n  out  CH  complementary outputs (PWM_DEADTIME_EN only)

## Operation
- Reset: cnt=0; signal=0; signal_n=0; load_ack=0; period_start=0; pending flag cleared; active period/set/rst = 0.
- Counter: while en=1, cnt increments; when cnt==period_a it wraps to 0 on the next edge. The wrap condition is (cnt==period_a && en).
- Shadow load:
  - load=1 captures period, set_val and rst_val into the shadow registers and sets pending.
  - A later load before the wrap overwrites the shadow; the last value wins.
  - At the wrap with pending=1, shadow→active, pending clears and load_ack pulses.
  - If load and wrap occur in the same cycle, the new values are taken at that wrap.
- Channel i, evaluated on active values:
  - cnt==rst_a[i] → signal[i] cleared.
  - Else cnt==set_a[i] → signal[i] set.
  - Else signal[i] holds.
  - Reset has priority when set_a[i]==rst_a[i], so the channel stays low.
- Compare value > period_a: that edge never occurs, and the channel keeps its state across periods. This gives 0% or 100% duty.
- period_a==0: wrap every cycle and cnt is always 0.
- en=0:
  - cnt→0 and signal→0 on the next edge.
  - A pending load is applied immediately on that edge (load_ack pulses).
  - On re-enable, counting starts at 0.
- Arithmetic: unsigned, W bits; cnt never exceeds period_a.

## Timing
- signal lags its compare match by one cycle. For example, with set_a=3 and rst_a=7, signal is high exactly in the cycles where cnt is 4..7 and low otherwise (duty = (rst-set)/(period+1)).
- load_ack is asserted in the first cycle of the period that uses the new values, which is the cycle where cnt==0.
- period_start is combinational from cnt and en, with zero latency.
- Reset mid-period takes precedence over everything; it discards any pending load.

## Configuration
- PWM_DEADTIME_EN defined:
  - Adds the dead input and the signal_n output.
  - signal_n is the complement of the ideal output with insertion delay.
  - After any edge of a channel's ideal output, both signal[i] and signal_n[i] stay low for dead cycles; then the newly active side rises.
  - signal[i] and signal_n[i] are never both high.
  - dead=0 gives a plain complement with the same one-cycle latency.
  - A pulse shorter than dead cycles is suppressed entirely.
- Undefined: neither port exists and signal behaves exactly as described under Operation.

## Structure
- Shared package pwm_pkg: default parameter constants and the channel-slice helper for CH*W packing.
- Sub-module pwm_channel: per-channel compare, set/reset-priority flop and the optional dead-time generator. Instantiate it CH times in a generate loop; the counter and shadow logic stay in pwm_bank.

## Test plan
- Basic waveform: reset, en=1, period=9, ch0 set=2/rst=6 → signal[0] high for cnt 3..6, period_start every 10 cycles.
- Reload at boundary: at cnt=5, pulse load with ch0 set=0/rst=9 → old waveform finishes; load_ack at the next cnt==0; new duty from that period on.
- Boundary values: set==rst=4 → signal stays 0; set=0/rst=15 with period=9 → signal stays 1 after the first match; period=0 → cnt stuck at 0.
- Enable/reset mid-operation: en=0 at cnt=4 → cnt=0 and signal=0 next edge, pending load applied; reset during a pending load → load discarded, all outputs 0.
- Channel independence: CH=4 with distinct set/rst per channel → each duty matches its own values, with no crosstalk.
- PWM_DEADTIME_EN: dead=2, set=2/rst=6 → signal_n falls at the first edge, then 2 cycles with both low before signal rises; signal and signal_n are never high together; a pulse of 1 cycle is suppressed.
